// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: write side, read side, error clear and status.
// The master modport belongs to the user logic driving the FIFO; the slave modport belongs to the FIFO.
interface sync_fifo_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   logic [DATA_WIDTH-1:0]    i_Wr_Data;
   logic                     i_Wr_En;
   logic                     i_Rd_En;
   logic                     i_Clr_Err;
   logic [DATA_WIDTH-1:0]    o_Rd_Data;
   logic                     o_Data_Valid;
   logic                     o_Full;
   logic                     o_Empty;
   logic                     o_Almost_Full;
   logic                     o_Almost_Empty;
   logic [$clog2(DEPTH):0]   o_Count;
   logic                     o_Overflow;
   logic                     o_Underflow;

   modport master (
      output i_Wr_Data, i_Wr_En, i_Rd_En, i_Clr_Err,
      input  o_Rd_Data, o_Data_Valid, o_Full, o_Empty, o_Almost_Full,
             o_Almost_Empty, o_Count, o_Overflow, o_Underflow
   );

   modport slave (
      input  i_Wr_Data, i_Wr_En, i_Rd_En, i_Clr_Err,
      output o_Rd_Data, o_Data_Valid, o_Full, o_Empty, o_Almost_Full,
             o_Almost_Empty, o_Count, o_Overflow, o_Underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, almost-full/empty flags, sticky errors and optional FWFT read; status one edge after the request.
// No backpressure stall: a write when full (without a same-cycle pop) or a read when empty is dropped and latched as overflow/underflow.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   sync_fifo_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  empty;
   logic                  full;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  ovf_q;
   logic                  udf_q;

   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);
   assign rd_acc = bus.i_Rd_En && !empty;
   // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
   assign wr_acc = bus.i_Wr_En && (!full || rd_acc);

   always_ff @(posedge i_Clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= bus.i_Wr_Data;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A fresh error in the clearing cycle must not be lost, so set has priority.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.i_Wr_En && !wr_acc) begin
            ovf_q <= 1'b1;
         end else if (bus.i_Clr_Err) begin
            ovf_q <= 1'b0;
         end
         if (bus.i_Rd_En && !rd_acc) begin
            udf_q <= 1'b1;
         end else if (bus.i_Clr_Err) begin
            udf_q <= 1'b0;
         end
      end
   end

   assign bus.o_Count        = count;
   assign bus.o_Empty        = empty;
   assign bus.o_Full         = full;
   assign bus.o_Almost_Full  = (count >= AF_CNT);
   assign bus.o_Almost_Empty = (count <= AE_CNT);
   assign bus.o_Overflow     = ovf_q;
   assign bus.o_Underflow    = udf_q;

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is shown directly; masked while empty so reset presents zero.
         assign bus.o_Rd_Data    = empty ? '0 : mem[rd_ptr];
         assign bus.o_Data_Valid = !empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_q;
         logic                  rd_vld_q;

         always_ff @(posedge i_Clk or negedge i_Reset) begin
            if (!i_Reset) begin
               rd_data_q <= '0;
               rd_vld_q  <= 1'b0;
            end else begin
               rd_vld_q <= rd_acc;
               if (rd_acc) begin
                  rd_data_q <= mem[rd_ptr];
               end
            end
         end

         assign bus.o_Rd_Data    = rd_data_q;
         assign bus.o_Data_Valid = rd_vld_q;
      end
   endgenerate

   a_count_bound: assert property (@(posedge i_Clk) disable iff (!i_Reset) count <= FULL_CNT);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param in both read modes against a queue-based reference model.
module tb_sync_fifo_param;
   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) b0 ();
   sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) b1 ();

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
      dut0 (.i_Clk(clk), .i_Reset(rst0), .bus(b0));
   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
      dut1 (.i_Clk(clk), .i_Reset(rst1), .bus(b1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain queues, updated with the request rules at each edge.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       m0_vld = 1'b0, m0_ovf = 1'b0, m0_udf = 1'b0;
   logic [7:0] m0_dat = 8'h00;
   logic       m1_ovf = 1'b0, m1_udf = 1'b0;

   always @(posedge clk or negedge rst0) begin
      if (!rst0) begin
         q0.delete();
         m0_vld <= 1'b0; m0_dat <= 8'h00; m0_ovf <= 1'b0; m0_udf <= 1'b0;
      end else begin
         automatic bit rd_ok = b0.i_Rd_En && (q0.size() > 0);
         automatic bit wr_ok = b0.i_Wr_En && ((q0.size() < 16) || rd_ok);
         m0_vld <= rd_ok;
         if (rd_ok) m0_dat <= q0.pop_front();
         if (wr_ok) q0.push_back(b0.i_Wr_Data);
         m0_ovf <= (b0.i_Wr_En && !wr_ok) ? 1'b1 : (b0.i_Clr_Err ? 1'b0 : m0_ovf);
         m0_udf <= (b0.i_Rd_En && !rd_ok) ? 1'b1 : (b0.i_Clr_Err ? 1'b0 : m0_udf);
      end
   end

   always @(posedge clk or negedge rst1) begin
      if (!rst1) begin
         q1.delete();
         m1_ovf <= 1'b0; m1_udf <= 1'b0;
      end else begin
         automatic bit rd_ok = b1.i_Rd_En && (q1.size() > 0);
         automatic bit wr_ok = b1.i_Wr_En && ((q1.size() < 16) || rd_ok);
         if (rd_ok) void'(q1.pop_front());
         if (wr_ok) q1.push_back(b1.i_Wr_Data);
         m1_ovf <= (b1.i_Wr_En && !wr_ok) ? 1'b1 : (b1.i_Clr_Err ? 1'b0 : m1_ovf);
         m1_udf <= (b1.i_Rd_En && !rd_ok) ? 1'b1 : (b1.i_Clr_Err ? 1'b0 : m1_udf);
      end
   end

   // Every falling edge: all outputs of both instances against the model.
   always @(negedge clk) begin
      chk("m0_count", b0.o_Count, q0.size());
      chk("m0_empty", b0.o_Empty, q0.size() == 0);
      chk("m0_full",  b0.o_Full,  q0.size() == 16);
      chk("m0_afull", b0.o_Almost_Full,  q0.size() >= 14);
      chk("m0_aempty", b0.o_Almost_Empty, q0.size() <= 2);
      chk("m0_ovf", b0.o_Overflow, m0_ovf);
      chk("m0_udf", b0.o_Underflow, m0_udf);
      chk("m0_vld", b0.o_Data_Valid, m0_vld);
      chk("m0_data", b0.o_Rd_Data, m0_dat);
      chk("m1_count", b1.o_Count, q1.size());
      chk("m1_empty", b1.o_Empty, q1.size() == 0);
      chk("m1_full",  b1.o_Full,  q1.size() == 16);
      chk("m1_afull", b1.o_Almost_Full,  q1.size() >= 14);
      chk("m1_aempty", b1.o_Almost_Empty, q1.size() <= 2);
      chk("m1_ovf", b1.o_Overflow, m1_ovf);
      chk("m1_udf", b1.o_Underflow, m1_udf);
      chk("m1_vld", b1.o_Data_Valid, q1.size() > 0);
      if (q1.size() > 0) chk("m1_data", b1.o_Rd_Data, q1[0]);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rx;
      rst0 = 1'b0; rst1 = 1'b0;
      b0.i_Wr_Data = 8'h00; b0.i_Wr_En = 1'b0; b0.i_Rd_En = 1'b0; b0.i_Clr_Err = 1'b0;
      b1.i_Wr_Data = 8'h00; b1.i_Wr_En = 1'b0; b1.i_Rd_En = 1'b0; b1.i_Clr_Err = 1'b0;
      repeat (3) tick();
      rst0 = 1'b1; rst1 = 1'b1;
      tick();
      chk("rst_empty", b0.o_Empty, 1);
      chk("rst_aempty", b0.o_Almost_Empty, 1);
      chk("rst_count", b0.o_Count, 0);
      chk("rst_full", b0.o_Full, 0);
      chk("rst_afull", b0.o_Almost_Full, 0);
      chk("rst_data", b0.o_Rd_Data, 0);
      chk("rst_vld", b0.o_Data_Valid, 0);
      chk("rst_ovf", b0.o_Overflow, 0);
      chk("rst_udf", b0.o_Underflow, 0);
      chk("rst1_vld", b1.o_Data_Valid, 0);
      chk("rst1_data", b1.o_Rd_Data, 0);

      // Fill to full, then one dropped write.
      for (int i = 0; i < 16; i++) begin
         b0.i_Wr_En = 1'b1; b0.i_Wr_Data = 8'(i);
         tick();
         chk("fill_count", b0.o_Count, i + 1);
         if (i == 12) chk("fill_afull_13", b0.o_Almost_Full, 0);
         if (i == 13) chk("fill_afull_14", b0.o_Almost_Full, 1);
         if (i == 14) chk("fill_full_15", b0.o_Full, 0);
      end
      chk("fill_full", b0.o_Full, 1);
      chk("fill_count16", b0.o_Count, 16);
      b0.i_Wr_Data = 8'hAA;
      tick();
      b0.i_Wr_En = 1'b0;
      chk("ovf_set", b0.o_Overflow, 1);
      chk("ovf_count", b0.o_Count, 16);
      b0.i_Clr_Err = 1'b1;
      tick();
      b0.i_Clr_Err = 1'b0;
      chk("ovf_clr", b0.o_Overflow, 0);

      // Drain 17 times: data 0x00..0x0F, then the underflow.
      for (int i = 0; i < 17; i++) begin
         b0.i_Rd_En = 1'b1;
         tick();
         if (i < 16) begin
            chk("drain_vld", b0.o_Data_Valid, 1);
            chk("drain_data", b0.o_Rd_Data, i);
         end
      end
      b0.i_Rd_En = 1'b0;
      chk("drain_last_vld", b0.o_Data_Valid, 0);
      chk("drain_udf", b0.o_Underflow, 1);
      chk("drain_empty", b0.o_Empty, 1);
      b0.i_Clr_Err = 1'b1;
      tick();
      b0.i_Clr_Err = 1'b0;

      // Write and read together while empty.
      b0.i_Wr_En = 1'b1; b0.i_Rd_En = 1'b1; b0.i_Wr_Data = 8'h77;
      tick();
      b0.i_Rd_En = 1'b0;
      chk("wr_rd_empty_count", b0.o_Count, 1);
      chk("wr_rd_empty_udf", b0.o_Underflow, 1);
      chk("wr_rd_empty_vld", b0.o_Data_Valid, 0);
      b0.i_Wr_En = 1'b0; b0.i_Clr_Err = 1'b1;
      tick();
      b0.i_Clr_Err = 1'b0;

      // Top up to full, then write and read together while full.
      for (int i = 0; i < 15; i++) begin
         b0.i_Wr_En = 1'b1; b0.i_Wr_Data = 8'(8'h80 + i);
         tick();
      end
      b0.i_Rd_En = 1'b1; b0.i_Wr_Data = 8'h99;
      tick();
      b0.i_Wr_En = 1'b0; b0.i_Rd_En = 1'b0;
      chk("wr_rd_full_count", b0.o_Count, 16);
      chk("wr_rd_full_ovf", b0.o_Overflow, 0);
      chk("wr_rd_full_data", b0.o_Rd_Data, 8'h77);
      b0.i_Rd_En = 1'b1;
      repeat (16) tick();
      b0.i_Rd_En = 1'b0;
      chk("full_tail_data", b0.o_Rd_Data, 8'h99);
      chk("full_tail_empty", b0.o_Empty, 1);

      // 40-word stream through both pointer wraps.
      rx = 0;
      for (int k = 0; k < 41; k++) begin
         b0.i_Wr_En = (k < 40); b0.i_Wr_Data = 8'(k + 32);
         b0.i_Rd_En = (k >= 1);
         tick();
         chk("wrap_cnt_le2", b0.o_Count <= 2, 1);
         if (b0.o_Data_Valid) begin
            chk("wrap_order", b0.o_Rd_Data, 8'(rx + 32));
            rx++;
         end
      end
      b0.i_Wr_En = 1'b0; b0.i_Rd_En = 1'b0;
      chk("wrap_rx", rx, 40);
      chk("wrap_ovf", b0.o_Overflow, 0);
      chk("wrap_udf", b0.o_Underflow, 0);

      // FWFT instance.
      b1.i_Wr_En = 1'b1; b1.i_Wr_Data = 8'h55;
      tick();
      b1.i_Wr_En = 1'b0;
      chk("fwft_vld", b1.o_Data_Valid, 1);
      chk("fwft_head", b1.o_Rd_Data, 8'h55);
      b1.i_Wr_En = 1'b1; b1.i_Wr_Data = 8'h66;
      tick();
      b1.i_Wr_En = 1'b0;
      chk("fwft_head_kept", b1.o_Rd_Data, 8'h55);
      b1.i_Rd_En = 1'b1;
      tick();
      b1.i_Rd_En = 1'b0;
      chk("fwft_pop", b1.o_Rd_Data, 8'h66);
      chk("fwft_pop_count", b1.o_Count, 1);
      for (int i = 0; i < 2; i++) begin
         b1.i_Wr_En = 1'b1; b1.i_Wr_Data = 8'(8'hC0 + i);
         tick();
      end
      b1.i_Wr_En = 1'b0;
      chk("fwft_three", b1.o_Count, 3);
      #2;
      rst1 = 1'b0;
      #1;
      chk("fwft_rst_empty", b1.o_Empty, 1);
      chk("fwft_rst_vld", b1.o_Data_Valid, 0);
      chk("fwft_rst_count", b1.o_Count, 0);
      repeat (2) tick();
      rst1 = 1'b1;
      tick();
      chk("fwft_post_empty", b1.o_Empty, 1);
      chk("fwft_post_vld", b1.o_Data_Valid, 0);
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. It adds configurable depth, a fill-level count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer, and is driven and checked through the existing clocking-block style testbench.

## Interface
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 16, number of entries. Must be a power of 2 and at least 2.
- AF_THRESH, DEPTH-2, o_Almost_Full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2, o_Almost_Empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

- i_Clk  input  1  clock; all state updates on the rising edge.
- i_Reset  input  1  asynchronous, active-low reset.
- i_Wr_Data  input  DATA_WIDTH  write data.
- i_Wr_En  input  1  write request.
- i_Rd_En  input  1  read request (FWFT=0) or pop acknowledge (FWFT=1).
- i_Clr_Err  input  1  synchronous clear of the sticky error flags.
- o_Rd_Data  output  DATA_WIDTH  read data.
- o_Data_Valid  output  1  o_Rd_Data is valid.
- o_Full  output  1  count == DEPTH.
- o_Empty  output  1  count == 0.
- o_Almost_Full  output  1  count >= AF_THRESH.
- o_Almost_Empty  output  1  count <= AE_THRESH.
- o_Count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- o_Overflow  output  1  sticky: a write was rejected.
- o_Underflow  output  1  sticky: a read was rejected.

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count register: count_next = count + wr_acc - rd_acc. All status flags are decoded from the registered count.
- rd_acc = i_Rd_En && !o_Empty.
- wr_acc = i_Wr_En && (!o_Full || rd_acc). A write to a full FIFO succeeds only if a read is accepted in the same cycle.
- Simultaneous write and read:
  - Both accepted: count unchanged, both pointers advance.
  - When empty: the write is accepted and the read is rejected, so underflow is set.
- Rejected write: memory, pointer and count are unchanged; o_Overflow is set.
- Rejected read: pointer and count are unchanged; o_Data_Valid does not assert; o_Underflow is set.
- Sticky errors: cleared by i_Clr_Err. If a new error occurs in the same cycle as i_Clr_Err, the set wins.
- FWFT=0 (standard read):
  - o_Rd_Data is registered from mem[rd_ptr] on rd_acc.
  - o_Data_Valid pulses for one cycle after each rd_acc.
  - o_Rd_Data holds its last value otherwise.
- FWFT=1 (first-word-fall-through):
  - o_Rd_Data = mem[rd_ptr] (head word).
  - o_Data_Valid = !o_Empty.
  - i_Rd_En pops the head. The next word appears in the same cycle that the pointer advances.
- Invariant, both modes: o_Data_Valid is never 1 while o_Empty is 1 with count 0 in FWFT=1. In FWFT=0 it is never 1 without a preceding rd_acc.

## Timing
- Reset (asynchronous, on i_Reset low):
  - Pointers = 0, count = 0, o_Count = 0.
  - o_Empty = 1, o_Almost_Empty = 1, o_Full = 0, o_Almost_Full = 0.
  - o_Rd_Data = 0, o_Data_Valid = 0, o_Overflow = 0, o_Underflow = 0.
  - Reset asserted mid-operation discards all contents immediately. There is no read or write on the deassertion edge unless requested.
- Write latency: a word written at edge N is counted and flagged after edge N.
  - FWFT=0: the earliest read is requested in cycle N+1 and returns data after edge N+1.
  - FWFT=1: the word is visible on o_Rd_Data with o_Data_Valid=1 after edge N.
- Read latency, FWFT=0: one cycle from the i_Rd_En sample edge to o_Rd_Data/o_Data_Valid.
- Flags and o_Count update on the same edge as the pointers. There are no combinational paths from i_Wr_En to the status outputs.
- Error flags assert on the edge following the offending request.

## Test plan
- Reset: hold i_Reset=0 for 3 cycles, then release -> o_Empty=1, o_Almost_Empty=1, o_Count=0, all other outputs 0.
- Fill and overflow (DEPTH=16, AF_THRESH=14): write 0x00..0x0F, then one extra write 0xAA -> o_Almost_Full=1 after the 14th write; o_Full=1 and o_Count=16 after the 16th; 0xAA is dropped and o_Overflow=1. Pulse i_Clr_Err -> o_Overflow=0.
- Drain and underflow (FWFT=0): read 17 times -> data 0x00..0x0F in order, each one cycle after its request. The 17th read gives no o_Data_Valid and sets o_Underflow=1; o_Empty=1.
- Simultaneous access:
  - At full, write and read in the same cycle -> both accepted, o_Count stays 16, no overflow.
  - At empty, write and read in the same cycle -> o_Count=1, o_Underflow=1.
- Wrap-around: stream 40 words with continuous interleaved write/read -> output order is preserved across two pointer wraps, o_Count never exceeds 2, and no errors occur.
- FWFT=1 and reset mid-stream:
  - Write 0x55 -> after the next edge o_Data_Valid=1 and o_Rd_Data=0x55 with no i_Rd_En.
  - Write 0x66, then pulse i_Rd_En -> o_Rd_Data=0x66.
  - Assert i_Reset with 3 words stored -> o_Empty=1 and o_Data_Valid=0 immediately, without waiting for a clock edge.
